// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller: game states, collision
// codes, direction button bit positions and the update-period helper.
package snake_pkg;

    // Game states, encoded exactly as presented on state_o
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PLAY      = 2'b01,
        PAUSE     = 2'b10,
        GAME_OVER = 2'b11
    } game_state_t;

    // Collision codes from the collision unit (2'b11 behaves like COLLISION)
    localparam logic [1:0] NONE            = 2'b00;
    localparam logic [1:0] COLLISION       = 2'b01;
    localparam logic [1:0] APPLE_COLLECTED = 2'b10;

    // Bit positions inside btn_dir = {up, down, left, right}
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    // Frames per snake update at a given level; signed 32-bit arithmetic so
    // a large level*step cannot wrap below the floor.
    function automatic int speed_period(input int level_v, input int base,
                                        input int step, input int min_p);
        int dec;
        dec = level_v * step;
        if (base - dec > min_p) begin
            return base - dec;
        end
        return min_p;
    endfunction

endpackage

// File: rtl/snake_speed_timer.sv
// Frame counter that turns the per-frame strobe into the snake update tick.
// The period shrinks with the speed level down to a fixed floor.
module snake_speed_timer
    import snake_pkg::*;
#(
    parameter int LEVEL_W     = 3,
    parameter int BASE_PERIOD = 8,
    parameter int PERIOD_STEP = 1,
    parameter int MIN_PERIOD  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] level,
    input  logic               frame_start,
    output logic               update
);

    localparam int MAX_P = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [CNT_W-1:0] period_last;
    logic             update_reg, update_next;

    // Last frame index of the current period (period - 1)
    always_comb begin
        period_last = CNT_W'(speed_period(int'(level), BASE_PERIOD, PERIOD_STEP, MIN_PERIOD) - 1);
    end

    // Count frames while enabled; wrap and fire the tick at the period end.
    // ">=" keeps the counter sane if the period shrinks below the count.
    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        update_next    = 1'b0;
        if (clear) begin
            frame_cnt_next = '0;
        end else if (enable && frame_start) begin
            if (frame_cnt_reg >= period_last) begin
                frame_cnt_next = '0;
                update_next    = 1'b1;
            end else begin
                frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Counter and tick registers
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= '0;
            update_reg    <= 1'b0;
        end else begin
            frame_cnt_reg <= frame_cnt_next;
            update_reg    <= update_next;
        end
    end

    assign update = update_reg;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: IDLE/PLAY/PAUSE/GAME_OVER state machine with score,
// length and level counters, apple lock, timed game-over hold and win detect.
// Optional macro HIGH_SCORE_EN adds a best-score register kept across games.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int SCORE_W          = 8,
    parameter int LEN_W            = 6,
    parameter int START_LEN        = 3,
    parameter int MAX_LEN          = 32,
    parameter int LEVEL_W          = 3,
    parameter int MAX_LEVEL        = 7,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int BASE_PERIOD      = 8,
    parameter int PERIOD_STEP      = 1,
    parameter int MIN_PERIOD       = 2,
    parameter int GAMEOVER_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [3:0]         btn_dir,
    input  logic               btn_pause,
    input  logic [1:0]         collision_i,
    output logic [1:0]         state_o,
    output logic               update_o,
    output logic               apple_trigger_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [LEN_W-1:0]   length_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               win_o,
    output logic [SCORE_W-1:0] high_score_o
);

    localparam int APL_W = $clog2(APPLES_PER_LEVEL) + 1;
    localparam int GO_W  = $clog2(GAMEOVER_FRAMES) + 1;

    game_state_t        state_reg, state_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [APL_W-1:0]   apple_cnt_reg, apple_cnt_next;
    logic [GO_W-1:0]    go_cnt_reg, go_cnt_next;
    logic               win_reg, win_next;
    logic               lock_reg, lock_next;
    logic               trigger_reg, trigger_next;
    logic               pause_prev_reg;

    logic               pause_edge, dir_any, hit, apple_hit;
    logic               timer_clear, timer_enable, update;
    logic [LEN_W-1:0]   len_inc;

    assign pause_edge = btn_pause & ~pause_prev_reg;
    assign dir_any    = btn_dir[BTN_UP] | btn_dir[BTN_DOWN] | btn_dir[BTN_LEFT] | btn_dir[BTN_RIGHT];
    // Codes 01 and 11 are both fatal, so only the low bit matters
    assign hit        = collision_i[0];
    assign apple_hit  = (collision_i == APPLE_COLLECTED);
    assign len_inc    = (len_reg < LEN_W'(MAX_LEN)) ? len_reg + LEN_W'(1) : len_reg;

    snake_speed_timer #(
        .LEVEL_W    (LEVEL_W),
        .BASE_PERIOD(BASE_PERIOD),
        .PERIOD_STEP(PERIOD_STEP),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .enable     (timer_enable),
        .level      (level_reg),
        .frame_start(frame_start),
        .update     (update)
    );

    // Next-state and counter logic; PLAY priorities: collision, pause edge, normal
    always_comb begin
        state_next     = state_reg;
        score_next     = score_reg;
        len_next       = len_reg;
        level_next     = level_reg;
        apple_cnt_next = apple_cnt_reg;
        win_next       = win_reg;
        lock_next      = lock_reg & ~update;
        go_cnt_next    = go_cnt_reg;
        trigger_next   = 1'b0;
        timer_clear    = 1'b0;
        timer_enable   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dir_any) begin
                    state_next     = PLAY;
                    score_next     = '0;
                    len_next       = LEN_W'(START_LEN);
                    level_next     = '0;
                    apple_cnt_next = '0;
                    win_next       = 1'b0;
                    lock_next      = 1'b0;
                    timer_clear    = 1'b1;
                end
            end
            PLAY: begin
                if (hit) begin
                    state_next  = GAME_OVER;
                    win_next    = 1'b0;
                    go_cnt_next = '0;
                end else if (pause_edge) begin
                    state_next = PAUSE;
                end else begin
                    timer_enable = 1'b1;
                    if (apple_hit && !lock_reg) begin
                        score_next   = (score_reg == '1) ? score_reg : score_reg + SCORE_W'(1);
                        len_next     = len_inc;
                        lock_next    = 1'b1;
                        trigger_next = 1'b1;
                        if (apple_cnt_reg == APL_W'(APPLES_PER_LEVEL - 1)) begin
                            apple_cnt_next = '0;
                            if (level_reg < LEVEL_W'(MAX_LEVEL)) begin
                                level_next = level_reg + LEVEL_W'(1);
                            end
                        end else begin
                            apple_cnt_next = apple_cnt_reg + APL_W'(1);
                        end
                        if (len_inc == LEN_W'(MAX_LEN)) begin
                            state_next  = GAME_OVER;
                            win_next    = 1'b1;
                            go_cnt_next = '0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (pause_edge) begin
                    state_next = PLAY;
                end
            end
            GAME_OVER: begin
                if (frame_start) begin
                    if (go_cnt_reg == GO_W'(GAMEOVER_FRAMES - 1)) begin
                        state_next  = IDLE;
                        go_cnt_next = '0;
                    end else begin
                        go_cnt_next = go_cnt_reg + GO_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            score_reg      <= '0;
            len_reg        <= LEN_W'(START_LEN);
            level_reg      <= '0;
            apple_cnt_reg  <= '0;
            go_cnt_reg     <= '0;
            win_reg        <= 1'b0;
            lock_reg       <= 1'b0;
            trigger_reg    <= 1'b0;
            pause_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            score_reg      <= score_next;
            len_reg        <= len_next;
            level_reg      <= level_next;
            apple_cnt_reg  <= apple_cnt_next;
            go_cnt_reg     <= go_cnt_next;
            win_reg        <= win_next;
            lock_reg       <= lock_next;
            trigger_reg    <= trigger_next;
            pause_prev_reg <= btn_pause;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_reg;
    logic               enter_over;

    // Only a game ending from PLAY can set a new best (covers win and crash)
    assign enter_over = (state_reg == PLAY) && (state_next == GAME_OVER);

    // Best-score register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            high_reg <= '0;
        end else if (enter_over && (score_next > high_reg)) begin
            high_reg <= score_next;
        end
    end

    assign high_score_o = high_reg;
`else
    assign high_score_o = '0;
`endif

    assign state_o         = state_reg;
    assign update_o        = update;
    assign apple_trigger_o = trigger_reg;
    assign score_o         = score_reg;
    assign length_o        = len_reg;
    assign level_o         = level_reg;
    assign win_o           = win_reg;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl against a game-rule reference model.
// Honours HIGH_SCORE_EN when expecting high_score_o.
module tb_snake_game_ctrl;

    localparam int START_LEN = 3;
    localparam int MAX_LEN   = 32;
    localparam int MAX_LEVEL = 7;
    localparam int APL       = 4;
    localparam int BASE      = 8;
    localparam int STEP      = 1;
    localparam int MINP      = 2;
    localparam int GOF       = 120;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_OVER = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic [3:0] btn_dir = 4'b0000;
    logic [1:0] collision_i = 2'b00;
    logic [1:0] state_o;
    logic       update_o, apple_trigger_o, win_o;
    logic [7:0] score_o, high_score_o;
    logic [5:0] length_o;
    logic [2:0] level_o;

    snake_game_ctrl #(
        .SCORE_W(8), .LEN_W(6), .START_LEN(START_LEN), .MAX_LEN(MAX_LEN),
        .LEVEL_W(3), .MAX_LEVEL(MAX_LEVEL), .APPLES_PER_LEVEL(APL),
        .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .MIN_PERIOD(MINP),
        .GAMEOVER_FRAMES(GOF)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .btn_dir(btn_dir),
        .btn_pause(btn_pause), .collision_i(collision_i), .state_o(state_o),
        .update_o(update_o), .apple_trigger_o(apple_trigger_o), .score_o(score_o),
        .length_o(length_o), .level_o(level_o), .win_o(win_o),
        .high_score_o(high_score_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int upd_total = 0;
    int apl_total = 0;

    // Pulse monitor, sampling between active edges
    always @(negedge clk) begin
        if (update_o === 1'b1) upd_total++;
        if (apple_trigger_o === 1'b1) apl_total++;
    end

    // Reference model: game rules in plain integers
    logic [1:0] m_state;
    int m_score, m_len, m_apples, m_frames, m_go, m_high, m_upd, m_apl;
    bit m_win, m_lock;

    function automatic int m_level();
        int l;
        l = m_apples / APL;
        return (l > MAX_LEVEL) ? MAX_LEVEL : l;
    endfunction

    function automatic int m_period();
        int p;
        p = BASE - m_level() * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_score = 0; m_len = START_LEN; m_apples = 0;
        m_frames = 0; m_go = 0; m_high = 0; m_win = 0; m_lock = 0;
    endtask

    task automatic model_game_over(input bit won);
        m_state = S_OVER; m_win = won; m_go = 0;
`ifdef HIGH_SCORE_EN
        if (m_score > m_high) m_high = m_score;
`endif
    endtask

    task automatic model_apple();
        if (m_state == S_PLAY && !m_lock) begin
            m_apples++;
            if (m_score < 255) m_score++;
            if (m_len < MAX_LEN) m_len++;
            m_lock = 1; m_apl++;
            if (m_len == MAX_LEN) model_game_over(1'b1);
        end
    endtask

    // One frame strobe; returns update_o seen the cycle after and the model's expectation
    task automatic advance_frame(output logic seen, output logic exp_upd);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        seen = update_o;
        exp_upd = 1'b0;
        if (m_state == S_PLAY) begin
            m_frames++;
            if (m_frames >= m_period()) begin
                exp_upd = 1'b1; m_frames = 0; m_lock = 0; m_upd++;
            end
        end else if (m_state == S_OVER) begin
            m_go++;
            if (m_go == GOF) m_state = S_IDLE;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk) btn_dir = 4'b0001 << $urandom_range(0, 3);
        @(negedge clk) btn_dir = 4'b0000;
        if (m_state == S_IDLE) begin
            m_state = S_PLAY; m_score = 0; m_len = START_LEN; m_apples = 0;
            m_frames = 0; m_win = 0; m_lock = 0;
        end
    endtask

    task automatic eat_apple();
        @(negedge clk) collision_i = 2'b10;
        repeat (2 + $urandom_range(0, 4)) @(negedge clk);
        collision_i = 2'b00;
        model_apple();
    endtask

    task automatic run_to_update(input string tag);
        logic seen, e;
        for (int k = 0; k < 16; k++) begin
            advance_frame(seen, e);
            checks++;
            if (seen !== e) begin
                failures++;
                $display("FAIL %s update frame %0d: got %0b expected %0b", tag, k, seen, e);
            end
            if (e) break;
        end
    endtask

    task automatic run_game_over(input string tag);
        logic seen, e;
        for (int k = 0; k < GOF; k++) begin
            advance_frame(seen, e);
            checks++;
            if (seen !== 1'b0 || state_o !== m_state) begin
                failures++;
                $display("FAIL %s hold frame %0d: update %0b state %0b expected update 0 state %0b",
                         tag, k, seen, state_o, m_state);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (state_o !== S_IDLE || update_o !== 1'b0 || apple_trigger_o !== 1'b0 || win_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: state %0b upd %0b apl %0b win %0b expected 00 0 0 0",
                     state_o, update_o, apple_trigger_o, win_o);
        end
        checks++;
        if (score_o !== 8'd0 || length_o !== 6'(START_LEN) || level_o !== 3'd0 || high_score_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_counters: score %0d len %0d level %0d high %0d expected 0 %0d 0 0",
                     score_o, length_o, level_o, high_score_o, START_LEN);
        end
    endtask

    task automatic test_start();
        press_start();
        checks++;
        if (state_o !== m_state || length_o !== 6'(m_len) || score_o !== 8'(m_score)) begin
            failures++;
            $display("FAIL start: state %0b len %0d score %0d expected %0b %0d %0d",
                     state_o, length_o, score_o, m_state, m_len, m_score);
        end
    endtask

    task automatic test_update_tick();
        logic seen, e;
        for (int k = 0; k < BASE; k++) begin
            advance_frame(seen, e);
            checks++;
            if (seen !== e) begin
                failures++;
                $display("FAIL tick frame %0d: got %0b expected %0b", k, seen, e);
            end
        end
        #1;
        checks++;
        if (upd_total !== m_upd) begin
            failures++;
            $display("FAIL tick_count: got %0d pulses expected %0d", upd_total, m_upd);
        end
    endtask

    task automatic test_apple_hold();
        logic seen, e;
        @(negedge clk) collision_i = 2'b10;
        for (int k = 0; k < 3; k++) begin
            advance_frame(seen, e);
            checks++;
            if (seen !== e) begin
                failures++;
                $display("FAIL apple_hold frame %0d: got %0b expected %0b", k, seen, e);
            end
        end
        collision_i = 2'b00;
        model_apple();
        #1;
        checks++;
        if (apl_total !== m_apl || score_o !== 8'(m_score) || length_o !== 6'(m_len)) begin
            failures++;
            $display("FAIL apple_hold: triggers %0d score %0d len %0d expected %0d %0d %0d",
                     apl_total, score_o, length_o, m_apl, m_score, m_len);
        end
        run_to_update("apple_hold");
    endtask

    task automatic test_pause();
        logic seen, e;
        int upd_before;
        @(negedge clk) btn_pause = 1'b1;
        @(negedge clk);
        m_state = S_PAUSE;
        checks++;
        if (state_o !== S_PAUSE) begin
            failures++;
            $display("FAIL pause_enter: state %0b expected %0b", state_o, S_PAUSE);
        end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        btn_pause = 1'b0;
        #1 upd_before = upd_total;
        for (int k = 0; k < 20; k++) begin
            collision_i = 2'($urandom_range(1, 3));
            btn_dir = 4'($urandom);
            advance_frame(seen, e);
            checks++;
            if (seen !== 1'b0 || state_o !== S_PAUSE) begin
                failures++;
                $display("FAIL pause_frame %0d: update %0b state %0b expected 0 %0b", k, seen, state_o, S_PAUSE);
            end
        end
        collision_i = 2'b00;
        btn_dir = 4'b0000;
        #1;
        checks++;
        if (upd_total !== upd_before) begin
            failures++;
            $display("FAIL pause_count: got %0d pulses expected %0d", upd_total, upd_before);
        end
        @(negedge clk) btn_pause = 1'b1;
        @(negedge clk) btn_pause = 1'b0;
        m_state = S_PLAY;
        checks++;
        if (state_o !== S_PLAY) begin
            failures++;
            $display("FAIL pause_exit: state %0b expected %0b", state_o, S_PLAY);
        end
    endtask

    task automatic test_collision_priority();
        @(negedge clk);
        collision_i = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
        btn_pause = 1'b1;
        @(negedge clk) collision_i = 2'b00;
        model_game_over(1'b0);
        checks++;
        if (state_o !== S_OVER || win_o !== 1'b0) begin
            failures++;
            $display("FAIL collision_pause: state %0b win %0b expected %0b 0", state_o, win_o, S_OVER);
        end
        @(negedge clk) btn_pause = 1'b0;
        run_game_over("collision");
        checks++;
        if (state_o !== S_IDLE || score_o !== 8'(m_score) || high_score_o !== 8'(m_high)) begin
            failures++;
            $display("FAIL collision_end: state %0b score %0d high %0d expected %0b %0d %0d",
                     state_o, score_o, high_score_o, S_IDLE, m_score, m_high);
        end
    endtask

    task automatic test_levels();
        press_start();
        checks++;
        if (state_o !== S_PLAY || score_o !== 8'd0 || length_o !== 6'(START_LEN) || level_o !== 3'd0) begin
            failures++;
            $display("FAIL restart: state %0b score %0d len %0d level %0d expected 01 0 %0d 0",
                     state_o, score_o, length_o, level_o, START_LEN);
        end
        for (int a = 0; a < 28; a++) begin
            run_to_update("levels");
            eat_apple();
            checks++;
            if (level_o !== 3'(m_level()) || score_o !== 8'(m_score) || length_o !== 6'(m_len)) begin
                failures++;
                $display("FAIL level apple %0d: level %0d score %0d len %0d expected %0d %0d %0d",
                         a, level_o, score_o, length_o, m_level(), m_score, m_len);
            end
        end
        run_to_update("levels_floor");
        run_to_update("levels_floor");
        #1;
        checks++;
        if (apl_total !== m_apl || upd_total !== m_upd) begin
            failures++;
            $display("FAIL level_counts: triggers %0d updates %0d expected %0d %0d",
                     apl_total, upd_total, m_apl, m_upd);
        end
    endtask

    task automatic test_win();
        eat_apple();
        checks++;
        if (state_o !== m_state || win_o !== m_win || length_o !== 6'(m_len) || score_o !== 8'(m_score)) begin
            failures++;
            $display("FAIL win: state %0b win %0b len %0d score %0d expected %0b %0b %0d %0d",
                     state_o, win_o, length_o, score_o, m_state, m_win, m_len, m_score);
        end
        run_game_over("win");
        checks++;
        if (win_o !== 1'b1 || score_o !== 8'(m_score) || high_score_o !== 8'(m_high)) begin
            failures++;
            $display("FAIL win_held: win %0b score %0d high %0d expected 1 %0d %0d",
                     win_o, score_o, high_score_o, m_score, m_high);
        end
    endtask

    task automatic test_reset_midgame();
        logic seen, e;
        press_start();
        for (int k = 0; k < 16 && m_frames != m_period() - 1; k++) begin
            advance_frame(seen, e);
            checks++;
            if (seen !== e) begin
                failures++;
                $display("FAIL midgame frame %0d: got %0b expected %0b", k, seen, e);
            end
        end
        @(negedge clk);
        frame_start = 1'b1; collision_i = 2'b10; reset = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; collision_i = 2'b00; reset = 1'b0;
        model_reset();
        checks++;
        if (update_o !== 1'b0 || apple_trigger_o !== 1'b0 || state_o !== S_IDLE) begin
            failures++;
            $display("FAIL midgame_reset_pulses: upd %0b apl %0b state %0b expected 0 0 00",
                     update_o, apple_trigger_o, state_o);
        end
        checks++;
        if (score_o !== 8'd0 || length_o !== 6'(START_LEN) || level_o !== 3'd0 || high_score_o !== 8'd0) begin
            failures++;
            $display("FAIL midgame_reset_counters: score %0d len %0d level %0d high %0d expected 0 %0d 0 0",
                     score_o, length_o, level_o, high_score_o, START_LEN);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (upd_total !== m_upd || apl_total !== m_apl) begin
            failures++;
            $display("FAIL midgame_counts: updates %0d triggers %0d expected %0d %0d",
                     upd_total, apl_total, m_upd, m_apl);
        end
    endtask

    initial begin
        m_upd = 0;
        m_apl = 0;
        model_reset();
        test_reset();
        test_start();
        test_update_tick();
        test_apple_hold();
        test_pause();
        test_collision_priority();
        test_levels();
        test_win();
        test_reset_midgame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
